// File: rtl/tsu0_pkg.sv
// rtl/tsu0_pkg.sv - shared widths and opcode encodings for the tsu0 core
package tsu0_pkg;

  localparam int ADDR_SIZE = 12;
  localparam int WORD_SIZE = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_HALT  = 4'h7,
    OP_JMP   = 4'h8,
    OP_JZ    = 4'h9
  } opcode_t;

  // Opcode lives in the top nibble of an instruction word.
  function automatic opcode_t opcode_of(input logic [WORD_SIZE-1:0] word);
    return opcode_t'(word[WORD_SIZE-1 -: 4]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign count     = count_q;
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction prefetch queue with redirect flush
module fetch_queue #(
  parameter int                  ADDR_SIZE = tsu0_pkg::ADDR_SIZE,
  parameter int                  WORD_SIZE = tsu0_pkg::WORD_SIZE,
  parameter int                  DEPTH     = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 sysclk,
  input  logic                 rst,
  output logic                 rom_en,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [WORD_SIZE-1:0] rom_data,
  input  logic                 redirect,
  input  logic [ADDR_SIZE-1:0] redirect_addr,
  output logic                 ir_valid,
  output logic [WORD_SIZE-1:0] ir_data,
  output logic [ADDR_SIZE-1:0] ir_pc,
  input  logic                 ir_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_SIZE + WORD_SIZE;

  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0] tag_q, tag_d;
  logic                 inflight_q, inflight_d;
  logic [CW-1:0]        count;
  logic                 full, empty;
  logic [EW-1:0]        head;
  logic                 pop, push, issue, has_credit;

  always_comb begin
    pop        = ~empty & ir_ready & ~redirect;
    // Every queued entry plus the outstanding read holds a slot.
    has_credit = ~full & (({1'b0, count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH));
    issue      = ~rst & ~redirect & (has_credit | pop);
    push       = inflight_q & ~redirect;
    inflight_d = issue;
    tag_d      = tag_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_addr;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_SIZE'(1);
      tag_d      = fetch_pc_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sysclk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({tag_q, rom_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign rom_en           = issue;
  assign rom_addr         = fetch_pc_q;
  assign ir_valid         = ~empty;
  assign {ir_pc, ir_data} = head;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector and scoreboard bench for fetch_queue
module tb_fetch_queue;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_addr = '0;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [11:0] ir_pc;
  logic        ir_ready = 1'b0;

  int total = 0;
  int bad = 0;

  fetch_queue dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .ir_valid      (ir_valid),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .ir_ready      (ir_ready)
  );

  always #5 sysclk = ~sysclk;

  // ROM content: word = address + 0x1000, one cycle read latency.
  always @(posedge sysclk) rom_data <= {4'h1, rom_addr};

  typedef struct {
    logic        rst;
    logic        redir;
    logic [11:0] raddr;
    logic        ready;
    logic        chk_ir;
    logic        exp_en;
    logic [11:0] exp_addr;
    logic        exp_valid;
    logic [11:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic d, input logic [11:0] a,
                              input logic rdy, input logic ch, input logic en,
                              input logic [11:0] ea, input logic v, input logic [11:0] p);
    vec_t x;
    x.rst = r; x.redir = d; x.raddr = a; x.ready = rdy; x.chk_ir = ch;
    x.exp_en = en; x.exp_addr = ea; x.exp_valid = v; x.exp_pc = p;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic drive(input logic r, input logic d, input logic [11:0] a, input logic rdy);
    rst = r; redirect = d; redirect_addr = a; ir_ready = rdy;
    #1;
  endtask

  task automatic expect_head(input string name, input logic [11:0] pc);
    check({name, "_valid"}, 32'(ir_valid), 32'd1);
    check({name, "_pc"}, 32'(ir_pc), 32'(pc));
    check({name, "_data"}, 32'(ir_data), 32'(pc) + 32'h1000);
  endtask

  logic [11:0] exp_pc;
  int          pops;
  logic        r_rst, r_redir, r_rdy;
  logic [11:0] r_addr;

  initial begin
    // Streaming from reset with ir_ready high.
    add(1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 12'h000, 0, 0);
    add(0, 0, 0, 1, 1, 1, 12'h001, 0, 0);
    add(0, 0, 0, 1, 1, 1, 12'h002, 1, 12'h000);
    add(0, 0, 0, 1, 1, 1, 12'h003, 1, 12'h001);
    add(0, 0, 0, 1, 1, 1, 12'h004, 1, 12'h002);
    // Reset mid-stream, then stall ten cycles: exactly four issues.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 12'h000, 0, 0);
    add(0, 0, 0, 0, 1, 1, 12'h001, 0, 0);
    add(0, 0, 0, 0, 1, 1, 12'h002, 1, 12'h000);
    add(0, 0, 0, 0, 1, 1, 12'h003, 1, 12'h000);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, 0, 0, 1, 12'h000);
    // Release: drain in order while fetch resumes at 4 without a gap.
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 1, 12'(4 + i), 1, 12'(i));
    // Reset with queue loaded and a read in flight.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 12'h000, 0, 0);
    add(0, 0, 0, 1, 1, 1, 12'h001, 0, 0);
    add(0, 0, 0, 1, 1, 1, 12'h002, 1, 12'h000);

    drive(1, 0, 0, 1);
    cyc(); cyc();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].raddr, vecs[i].ready);
      check($sformatf("v%0d_rom_en", i), 32'(rom_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      if (vecs[i].chk_ir) begin
        check($sformatf("v%0d_ir_valid", i), 32'(ir_valid), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
          check($sformatf("v%0d_ir_pc", i), 32'(ir_pc), 32'(vecs[i].exp_pc));
          check($sformatf("v%0d_ir_data", i), 32'(ir_data), 32'(vecs[i].exp_pc) + 32'h1000);
        end
      end
      cyc();
    end

    // Redirect with three queued entries and one read in flight.
    drive(1, 0, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0); cyc(); end
    drive(0, 1, 12'h0A0, 1);
    check("redir_rom_en", 32'(rom_en), 32'd0);
    cyc();
    drive(0, 0, 0, 1);
    check("redir_n1_valid", 32'(ir_valid), 32'd0);
    check("redir_n1_addr", {31'd0, rom_en} << 12 | 32'(rom_addr), 32'h10A0);
    cyc();
    check("redir_n2_valid", 32'(ir_valid), 32'd0);
    cyc();
    expect_head("redir_n3", 12'h0A0);
    cyc();
    expect_head("redir_n4", 12'h0A1);
    cyc();

    // Back-to-back redirects: only the second target survives.
    drive(0, 1, 12'h123, 1); cyc();
    drive(0, 1, 12'h200, 1);
    check("b2b_valid0", 32'(ir_valid), 32'd0);
    check("b2b_rom_en", 32'(rom_en), 32'd0);
    cyc();
    drive(0, 0, 0, 1);
    check("b2b_addr", 32'(rom_addr), 32'h200);
    check("b2b_valid1", 32'(ir_valid), 32'd0);
    cyc();
    check("b2b_valid2", 32'(ir_valid), 32'd0);
    cyc();
    expect_head("b2b_head", 12'h200);
    cyc();

    // Fetch address wraps from 0xFFF to 0x000.
    drive(0, 1, 12'hFFE, 1); cyc();
    drive(0, 0, 0, 1); cyc(); cyc();
    check("wrap_rom_addr", 32'(rom_addr), 32'h000);
    expect_head("wrap0", 12'hFFE); cyc();
    expect_head("wrap1", 12'hFFF); cyc();
    expect_head("wrap2", 12'h000); cyc();
    expect_head("wrap3", 12'h001); cyc();

    // Random ready/redirect/reset traffic against a pc-sequence scoreboard.
    exp_pc = 12'h000;
    pops = 0;
    for (int n = 0; n < 10000; n++) begin
      r_rst   = (n == 0) || ($urandom_range(0, 299) == 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_addr  = 12'($urandom);
      r_rdy   = $urandom_range(0, 1) == 1;
      drive(r_rst, r_redir, r_addr, r_rdy);
      if (r_rst) begin
        exp_pc = 12'h000;
      end else if (r_redir) begin
        exp_pc = r_addr;
      end else if (ir_valid && r_rdy) begin
        if (ir_pc !== exp_pc || ir_data !== {4'h1, exp_pc}) begin
          check("rand_pc", 32'(ir_pc), 32'(exp_pc));
          check("rand_data", 32'(ir_data), {20'd0, 4'h1, exp_pc});
        end else begin
          total++;
        end
        exp_pc = exp_pc + 12'd1;
        pops++;
      end
      if (dut.u_fifo.count > 3'd4) check("rand_count_bound", 32'(dut.u_fifo.count), 32'd4);
      cyc();
    end
    check("rand_pops_seen", 32'(pops > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
